// File: rtl/dma_axil_csr_if.sv
// AXI4-Lite bus bundle between the host CPU and the DMA CSR block.
// Signal names follow the AXI channel naming used elsewhere in the SoC.
interface dma_axil_csr_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/dma_axil_csr.sv
// AXI4-Lite control/status registers for the DMA engine.
// Holds the job registers, fires the start pulse and reports completion.
module dma_axil_csr #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   dma_axil_csr_if.slave      bus,
   output logic               trigger,
   output logic [31:0]        src_addr,
   output logic [31:0]        dest_addr,
   output logic [LEN_W-1:0]   length,
   input  logic               done,
   output logic               irq
);
   localparam int IW = ADDR_W - 2;

   logic          aw_full;
   logic          w_full;
   logic [IW-1:0] aw_idx;
   logic [31:0]   w_data;
   logic [3:0]    w_strb;
   logic          irq_en;
   logic          busy;
   logic          done_st;
   logic          done_q;

   logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic          commit, done_rise;
   logic          aw_full_n, w_full_n, bvalid_n, rvalid_n;
   logic [IW-1:0] ar_idx;
   logic [31:0]   rd_mux;
   logic          rd_err, wr_err, start_ok, w1c;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      logic [31:0] m;
      m = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
      return m;
   endfunction

   assign aw_hs     = bus.AWVALID & bus.AWREADY;
   assign w_hs      = bus.WVALID & bus.WREADY;
   assign ar_hs     = bus.ARVALID & bus.ARREADY;
   assign b_hs      = bus.BVALID & bus.BREADY;
   assign r_hs      = bus.RVALID & bus.RREADY;
   assign commit    = aw_full & w_full & ~bus.BVALID;
   assign done_rise = done & ~done_q;
   assign ar_idx    = bus.ARADDR[ADDR_W-1:2];

   always_comb begin
      aw_full_n = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full);
      w_full_n  = commit ? 1'b0 : (w_hs ? 1'b1 : w_full);
      bvalid_n  = commit ? 1'b1 : (b_hs ? 1'b0 : bus.BVALID);
      rvalid_n  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : bus.RVALID);
      wr_err    = aw_idx > IW'(4);
      start_ok  = commit & (aw_idx == IW'(0)) & w_strb[0]
                & w_data[0] & ~busy;
      w1c       = commit & (aw_idx == IW'(1)) & w_strb[0] & w_data[1];
   end

   always_comb begin
      rd_mux = '0;
      rd_err = 1'b0;
      case (ar_idx)
         IW'(0):  rd_mux = {30'b0, irq_en, 1'b0};
         IW'(1):  rd_mux = {30'b0, done_st, busy};
         IW'(2):  rd_mux = src_addr;
         IW'(3):  rd_mux = dest_addr;
         IW'(4):  rd_mux = 32'(length);
         default: rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         aw_full     <= 1'b0;
         w_full      <= 1'b0;
         aw_idx      <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         irq_en      <= 1'b0;
         busy        <= 1'b0;
         done_st     <= 1'b0;
         done_q      <= 1'b0;
         trigger     <= 1'b0;
         src_addr    <= '0;
         dest_addr   <= '0;
         length      <= '0;
         irq         <= 1'b0;
         bus.AWREADY <= 1'b0;
         bus.WREADY  <= 1'b0;
         bus.ARREADY <= 1'b0;
         bus.BVALID  <= 1'b0;
         bus.BRESP   <= 2'b00;
         bus.RVALID  <= 1'b0;
         bus.RDATA   <= '0;
         bus.RRESP   <= 2'b00;
      end else begin
         done_q      <= done;
         trigger     <= start_ok;
         aw_full     <= aw_full_n;
         w_full      <= w_full_n;
         bus.BVALID  <= bvalid_n;
         bus.RVALID  <= rvalid_n;
         bus.AWREADY <= ~aw_full_n & ~bvalid_n;
         bus.WREADY  <= ~w_full_n & ~bvalid_n;
         bus.ARREADY <= ~rvalid_n;
         if (aw_hs) aw_idx <= bus.AWADDR[ADDR_W-1:2];
         if (w_hs) begin
            w_data <= bus.WDATA;
            w_strb <= bus.WSTRB;
         end
         if (ar_hs) begin
            bus.RDATA <= rd_mux;
            bus.RRESP <= rd_err ? 2'b10 : 2'b00;
         end
         if (commit) begin
            bus.BRESP <= wr_err ? 2'b10 : 2'b00;
            case (aw_idx)
               IW'(0): if (w_strb[0]) irq_en <= w_data[1];
               IW'(2): if (!busy) src_addr <= merge(src_addr, w_data, w_strb);
               IW'(3): if (!busy) dest_addr <= merge(dest_addr, w_data, w_strb);
               IW'(4):
                  if (!busy)
                     for (int i = 0; i < LEN_W; i++)
                        if (w_strb[i/8]) length[i] <= w_data[i];
               default: ;
            endcase
         end
         // a completion edge outranks a same-cycle clear of DONE
         if (start_ok) begin
            busy    <= 1'b1;
            done_st <= 1'b0;
         end
         if (w1c) done_st <= 1'b0;
         if (done_rise) begin
            busy    <= 1'b0;
            done_st <= 1'b1;
         end
         irq <= done_st & irq_en;
      end
   end
endmodule

// File: tb/tb_dma_axil_csr.sv
// Self-checking bench for dma_axil_csr: vector table plus hand sequences
// for the multi-cycle handshake, start/done and reset corner cases.
module tb_dma_axil_csr;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        done = 1'b0;
   logic        trigger;
   logic        irq;
   logic [31:0] src_addr;
   logic [31:0] dest_addr;
   logic [5:0]  length;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t tbl[16];

   dma_axil_csr_if #(.ADDR_W(8)) bus ();

   dma_axil_csr #(.ADDR_W(8), .LEN_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .trigger   (trigger),
      .src_addr  (src_addr),
      .dest_addr (dest_addr),
      .length    (length),
      .done      (done),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] er,
                     output logic trig);
      logic aw_go, w_go, aw_ok, w_ok, b_ok;
      logic [1:0] resp, exp;
      trig  = 1'b0;
      aw_ok = 1'b0;
      w_ok  = 1'b0;
      b_ok  = 1'b0;
      resp  = 2'b00;
      bq.push_back(er);
      bus.AWADDR  = a;
      bus.AWVALID = 1'b1;
      bus.WDATA   = d;
      bus.WSTRB   = s;
      bus.WVALID  = 1'b1;
      for (int k = 0; k < 20 && !(aw_ok && w_ok); k++) begin
         aw_go = bus.AWVALID & bus.AWREADY;
         w_go  = bus.WVALID & bus.WREADY;
         tick();
         trig |= trigger;
         if (aw_go) begin
            aw_ok = 1'b1;
            bus.AWVALID = 1'b0;
         end
         if (w_go) begin
            w_ok = 1'b1;
            bus.WVALID = 1'b0;
         end
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b1;
      for (int k = 0; k < 20 && !b_ok; k++) begin
         if (bus.BVALID) begin
            b_ok = 1'b1;
            resp = bus.BRESP;
         end
         tick();
         trig |= trigger;
      end
      bus.BREADY = 1'b0;
      exp = bq.pop_front();
      chk($sformatf("wr_hs@%02h", a), 32'(aw_ok & w_ok & b_ok), 32'd1);
      chk($sformatf("bresp@%02h", a), 32'(resp), 32'(exp));
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] ed,
                     input logic [1:0] er);
      logic ok, got;
      logic [33:0] e;
      logic [31:0] d;
      logic [1:0]  r;
      rq.push_back({er, ed});
      ok  = 1'b0;
      got = 1'b0;
      d   = '0;
      r   = 2'b00;
      bus.ARADDR  = a;
      bus.ARVALID = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         ok = bus.ARREADY;
         tick();
      end
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         if (bus.RVALID) begin
            got = 1'b1;
            d   = bus.RDATA;
            r   = bus.RRESP;
         end
         tick();
      end
      bus.RREADY = 1'b0;
      e = rq.pop_front();
      chk($sformatf("rd_hs@%02h", a), 32'(ok & got), 32'd1);
      chk($sformatf("rdata@%02h", a), d, e[31:0]);
      chk($sformatf("rresp@%02h", a), 32'(r), 32'(e[33:32]));
   endtask

   initial begin
      logic t;
      tbl[0]  = '{1'b1, 8'h08, 32'h1000_0040, 4'hf, 32'h0, 2'b00};
      tbl[1]  = '{1'b0, 8'h08, 32'h0, 4'h0, 32'h1000_0040, 2'b00};
      tbl[2]  = '{1'b1, 8'h0C, 32'h2000_0080, 4'hf, 32'h0, 2'b00};
      tbl[3]  = '{1'b0, 8'h0C, 32'h0, 4'h0, 32'h2000_0080, 2'b00};
      tbl[4]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hf, 32'h0, 2'b00};
      tbl[5]  = '{1'b0, 8'h10, 32'h0, 4'h0, 32'h0000_003F, 2'b00};
      tbl[6]  = '{1'b1, 8'h14, 32'h1234_5678, 4'hf, 32'h0, 2'b10};
      tbl[7]  = '{1'b0, 8'h14, 32'h0, 4'h0, 32'h0, 2'b10};
      tbl[8]  = '{1'b1, 8'h08, 32'hAABB_CCDD, 4'b0010, 32'h0, 2'b00};
      tbl[9]  = '{1'b0, 8'h08, 32'h0, 4'h0, 32'h1000_CC40, 2'b00};
      tbl[10] = '{1'b1, 8'h00, 32'h2, 4'hf, 32'h0, 2'b00};
      tbl[11] = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h2, 2'b00};
      tbl[12] = '{1'b1, 8'h00, 32'h3, 4'b0010, 32'h0, 2'b00};
      tbl[13] = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h2, 2'b00};
      tbl[14] = '{1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[15] = '{1'b0, 8'h80, 32'h0, 4'h0, 32'h0, 2'b10};

      bus.AWADDR  = '0;
      bus.AWPROT  = '0;
      bus.AWVALID = 1'b1;
      bus.WDATA   = '0;
      bus.WSTRB   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;
      bus.ARADDR  = '0;
      bus.ARPROT  = '0;
      bus.ARVALID = 1'b1;
      bus.RREADY  = 1'b0;

      rst = 1'b0;
      repeat (3) tick();
      chk("rst_ready", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'd0);
      chk("rst_valid", 32'({bus.BVALID, bus.RVALID, trigger, irq}), 32'd0);
      chk("rst_regs", src_addr | dest_addr | 32'(length) | bus.RDATA
          | 32'(bus.BRESP) | 32'(bus.RRESP), 32'd0);
      bus.AWVALID = 1'b0;
      bus.ARVALID = 1'b0;
      rst = 1'b1;
      tick();
      chk("ready_after_rst", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'd7);
      chk("no_hs_in_rst", 32'({bus.BVALID, bus.RVALID}), 32'd0);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr)
            wr(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp, t);
         else
            rd(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp);
      end

      // W before AW, B back-pressured
      bus.WDATA  = 32'h3000_00C0;
      bus.WSTRB  = 4'hf;
      bus.WVALID = 1'b1;
      tick();
      bus.WVALID = 1'b0;
      chk("w_first_ready", 32'({bus.AWREADY, bus.WREADY}), 32'd2);
      tick();
      tick();
      bus.AWADDR  = 8'h0C;
      bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      chk("b_wait_commit", 32'(bus.BVALID), 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("b_held", 32'({bus.BVALID, bus.AWREADY, bus.WREADY}), 32'd4);
         tick();
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      chk("b_accepted", 32'({bus.BVALID, bus.AWREADY, bus.WREADY}), 32'd3);
      tick();
      chk("single_b", 32'(bus.BVALID), 32'd0);
      rd(8'h0C, 32'h3000_00C0, 2'b00);

      // start, trigger pulse, done, irq
      wr(8'h10, 32'd12, 4'hf, 2'b00, t);
      bus.AWADDR  = 8'h00;
      bus.WDATA   = 32'h3;
      bus.WSTRB   = 4'hf;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      chk("pre_commit", 32'({bus.BVALID, trigger}), 32'd0);
      tick();
      chk("trig_pulse", 32'({bus.BVALID, trigger, bus.BRESP}), 32'hC);
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      chk("trig_drop", 32'({trigger, bus.BVALID}), 32'd0);
      rd(8'h04, 32'h1, 2'b00);
      chk("job_regs", {src_addr[25:0], length}, {26'(32'h1000_CC40), 6'd12});
      chk("irq_idle", 32'(irq), 32'd0);
      done = 1'b1;
      tick();
      tick();
      chk("irq_set", 32'(irq), 32'd1);
      rd(8'h04, 32'h2, 2'b00);
      wr(8'h04, 32'h2, 4'hf, 2'b00, t);
      tick();
      chk("irq_clr", 32'(irq), 32'd0);
      rd(8'h04, 32'h0, 2'b00);

      // start while busy, job writes while busy, W1C vs done edge
      wr(8'h00, 32'h1, 4'hf, 2'b00, t);
      chk("start_trig", 32'(t), 32'd1);
      rd(8'h04, 32'h1, 2'b00);
      wr(8'h00, 32'h3, 4'hf, 2'b00, t);
      chk("start_busy_trig", 32'(t), 32'd0);
      wr(8'h0C, 32'hDEAD_BEEF, 4'hf, 2'b00, t);
      chk("dst_busy", dest_addr, 32'h3000_00C0);
      done = 1'b0;
      tick();
      bus.AWADDR  = 8'h04;
      bus.WDATA   = 32'h2;
      bus.WSTRB   = 4'hf;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      done = 1'b1;
      tick();
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      rd(8'h04, 32'h2, 2'b00);
      chk("irq_w1c_race", 32'(irq), 32'd1);

      // reset while B pending
      bus.AWADDR  = 8'h08;
      bus.WDATA   = 32'h55;
      bus.WSTRB   = 4'hf;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      tick();
      chk("b_pending", 32'(bus.BVALID), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_drop_b", 32'({bus.BVALID, irq}), 32'd0);
      chk("rst_src", src_addr, 32'd0);
      bus.BREADY = 1'b1;
      repeat (3) tick();
      bus.BREADY = 1'b0;
      chk("no_b_after_rst", 32'(bus.BVALID), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
